reg_map_wr_ctrl: RTL

Downstream consumer of the register-map write command stream produced by the DIP-switch command generator. Accepts one masked write at a time and validates the address and value. Applies a read-modify-write to a small configuration register bank (chirp period, DDC/DUC bypass, ADC packet enable, MAC speed). Returns a one-cycle response with an error code, and drives the configuration outputs consumed by the radar datapath.

---
 rtl/reg_map_pkg.sv | 34 +++
 rtl/reg_map_wr_ctrl_sat_cnt8.sv | 17 +
 rtl/reg_map_wr_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/reg_map_pkg.sv
// Shared constants for the register-map write path: address map, response
// codes, MAC speed encodings and the write controller's FSM states.
package reg_map_pkg;

    localparam logic [7:0] ADDR_CHIRP  = 8'h00;
    localparam logic [7:0] ADDR_DDC    = 8'h10;
    localparam logic [7:0] ADDR_ADC    = 8'h20;
    localparam logic [7:0] ADDR_MAC    = 8'h23;
    localparam logic [7:0] ADDR_STATUS = 8'h30;

    localparam logic [1:0] ERR_OK   = 2'b00;
    localparam logic [1:0] ERR_ADDR = 2'b01;
    localparam logic [1:0] ERR_VAL  = 2'b10;
    localparam logic [1:0] ERR_RO   = 2'b11;

    // 2'b00 and 2'b11 are reserved and rejected with ERR_VAL.
    localparam logic [1:0] MAC_SPEED_RSVD0 = 2'b00;
    localparam logic [1:0] MAC_SPEED_100M  = 2'b01;
    localparam logic [1:0] MAC_SPEED_1G    = 2'b10;
    localparam logic [1:0] MAC_SPEED_RSVD3 = 2'b11;

    localparam int UPD_CHIRP = 0;
    localparam int UPD_DDC   = 1;
    localparam int UPD_ADC   = 2;
    localparam int UPD_MAC   = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_APPLY  = 2'd2,
        ST_RESP   = 2'd3
    } wr_state_t;

endpackage

// File: rtl/reg_map_wr_ctrl_sat_cnt8.sv
// 8-bit event counter that holds at 255 instead of wrapping.
module sat_cnt8 (
    input  logic       aclk,
    input  logic       clr,
    input  logic       inc,
    output logic [7:0] count
);

    always_ff @(posedge aclk) begin
        if (clr) begin
            count <= 8'd0;
        end else if (inc && (count != 8'hFF)) begin
            count <= count + 8'd1;
        end
    end

endmodule

// File: rtl/reg_map_wr_ctrl.sv
// Masked read-modify-write controller for the radar configuration register
// bank; one command in flight, one-cycle response strobe, event counters.
module reg_map_wr_ctrl
    import reg_map_pkg::*;
#(
    parameter int                         REG_ADDR_WIDTH   = 8,
    parameter int                         CORE_DATA_WIDTH  = 32,
    parameter logic [CORE_DATA_WIDTH-1:0] CHIRP_PERIOD_RST = 32'd10
) (
    input  logic                       aclk,
    input  logic                       areset,
    // A command transfers on an edge where reg_map_wr_cmd=1 and
    // reg_map_wr_ready=1; cmd seen while ready=0 is dropped and counted.
    input  logic                       reg_map_wr_cmd,
    input  logic [REG_ADDR_WIDTH-1:0]  reg_map_wr_addr,
    input  logic [CORE_DATA_WIDTH-1:0] reg_map_wr_data,
    input  logic [CORE_DATA_WIDTH-1:0] reg_map_wr_keep,
    output logic                       reg_map_wr_ready,
    output logic                       reg_map_wr_valid,
    output logic [1:0]                 reg_map_wr_err,
    output logic [CORE_DATA_WIDTH-1:0] cfg_chirp_period,
    output logic                       cfg_ddc_duc_bypass,
    output logic                       cfg_adc_pkt_en,
    output logic [1:0]                 cfg_mac_speed,
    output logic [3:0]                 cfg_update,
    output logic [31:0]                cfg_status,
    output wr_state_t                  dbg_state
);

    wr_state_t                  state;
    logic [REG_ADDR_WIDTH-1:0]  cmd_addr;
    logic [CORE_DATA_WIDTH-1:0] cmd_data;
    logic [CORE_DATA_WIDTH-1:0] cmd_keep;

    logic [1:0]                 err_q;
    logic [3:0]                 upd_q;
    logic [CORE_DATA_WIDTH-1:0] merged_q;

    logic [1:0]                 dec_err;
    logic [3:0]                 dec_upd;
    logic [CORE_DATA_WIDTH-1:0] dec_merged;
    logic [1:0]                 mac_new;

    logic [7:0] wr_cnt;
    logic [7:0] err_cnt;
    logic [7:0] drop_cnt;

    // dec_upd is only set for an accepted write whose effective keep is nonzero.
    always_comb begin
        dec_err    = ERR_OK;
        dec_upd    = 4'b0000;
        dec_merged = '0;
        mac_new    = (cfg_mac_speed & ~cmd_keep[1:0]) | (cmd_data[1:0] & cmd_keep[1:0]);
        case (cmd_addr)
            REG_ADDR_WIDTH'(ADDR_CHIRP): begin
                dec_merged         = (cfg_chirp_period & ~cmd_keep) | (cmd_data & cmd_keep);
                dec_upd[UPD_CHIRP] = |cmd_keep;
            end
            REG_ADDR_WIDTH'(ADDR_DDC): begin
                dec_merged[0]    = (cfg_ddc_duc_bypass & ~cmd_keep[0]) | (cmd_data[0] & cmd_keep[0]);
                dec_upd[UPD_DDC] = cmd_keep[0];
            end
            REG_ADDR_WIDTH'(ADDR_ADC): begin
                dec_merged[0]    = (cfg_adc_pkt_en & ~cmd_keep[0]) | (cmd_data[0] & cmd_keep[0]);
                dec_upd[UPD_ADC] = cmd_keep[0];
            end
            REG_ADDR_WIDTH'(ADDR_MAC): begin
                dec_merged[1:0] = mac_new;
                if ((mac_new == MAC_SPEED_RSVD0) || (mac_new == MAC_SPEED_RSVD3)) begin
                    dec_err = ERR_VAL;
                end else begin
                    dec_upd[UPD_MAC] = |cmd_keep[1:0];
                end
            end
            REG_ADDR_WIDTH'(ADDR_STATUS): dec_err = ERR_RO;
            default:                      dec_err = ERR_ADDR;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state              <= ST_IDLE;
            reg_map_wr_ready   <= 1'b1;
            reg_map_wr_valid   <= 1'b0;
            reg_map_wr_err     <= ERR_OK;
            cfg_update         <= 4'b0000;
            cfg_chirp_period   <= CHIRP_PERIOD_RST;
            cfg_ddc_duc_bypass <= 1'b0;
            cfg_adc_pkt_en     <= 1'b0;
            cfg_mac_speed      <= MAC_SPEED_1G;
            cmd_addr           <= '0;
            cmd_data           <= '0;
            cmd_keep           <= '0;
            err_q              <= ERR_OK;
            upd_q              <= 4'b0000;
            merged_q           <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (reg_map_wr_cmd) begin
                        cmd_addr         <= reg_map_wr_addr;
                        cmd_data         <= reg_map_wr_data;
                        cmd_keep         <= reg_map_wr_keep;
                        reg_map_wr_ready <= 1'b0;
                        state            <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    err_q    <= dec_err;
                    upd_q    <= dec_upd;
                    merged_q <= dec_merged;
                    state    <= ST_APPLY;
                end
                ST_APPLY: begin
                    if (upd_q[UPD_CHIRP]) cfg_chirp_period   <= merged_q;
                    if (upd_q[UPD_DDC])   cfg_ddc_duc_bypass <= merged_q[0];
                    if (upd_q[UPD_ADC])   cfg_adc_pkt_en     <= merged_q[0];
                    if (upd_q[UPD_MAC])   cfg_mac_speed      <= merged_q[1:0];
                    reg_map_wr_valid <= 1'b1;
                    reg_map_wr_err   <= err_q;
                    cfg_update       <= upd_q;
                    state            <= ST_RESP;
                end
                ST_RESP: begin
                    reg_map_wr_valid <= 1'b0;
                    reg_map_wr_err   <= ERR_OK;
                    cfg_update       <= 4'b0000;
                    reg_map_wr_ready <= 1'b1;
                    state            <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    sat_cnt8 u_wr_cnt (
        .aclk  (aclk),
        .clr   (areset),
        .inc   (reg_map_wr_valid && (reg_map_wr_err == ERR_OK)),
        .count (wr_cnt)
    );

    sat_cnt8 u_err_cnt (
        .aclk  (aclk),
        .clr   (areset),
        .inc   (reg_map_wr_valid && (reg_map_wr_err != ERR_OK)),
        .count (err_cnt)
    );

    sat_cnt8 u_drop_cnt (
        .aclk  (aclk),
        .clr   (areset),
        .inc   (reg_map_wr_cmd && !reg_map_wr_ready),
        .count (drop_cnt)
    );

    assign cfg_status = {8'h00, drop_cnt, err_cnt, wr_cnt};
    assign dbg_state  = state;

endmodule
